// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer
//   Sits behind the rPLL and runs on its output clock. It qualifies the PLL
//   lock, sequences the release of the system reset, and services soft-reset
//   requests from the CPU. In RUN it also produces a one-cycle clock-enable
//   strobe every CE_DIV cycles for slow peripheral logic.
//
// Ports
//   clk          in   PLL output clock
//   rst_n        in   async active-low board reset
//   pll_lock     in   rPLL LOCK, asynchronous to clk
//   soft_rst_req in   soft-reset request level, honoured only in RUN
//   sys_rst_n    out  system reset, active-low (async assert, sync release)
//   ready        out  high only while in RUN
//   ce_tick      out  single-cycle enable strobe, every CE_DIV cycles in RUN
//   state        out  0 WAIT_LOCK, 1 STABILIZE, 2 RELEASE, 3 RUN
//   lock_lost    out  sticky: lock dropped in STABILIZE or RUN

// Two-flop synchroniser for the asynchronous lock input.
module pll_rst_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];
endmodule

module pll_rst_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CE_DIV             = 72
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       ce_tick,
  output logic [1:0] state,
  output logic       lock_lost
);
  // One counter serves both STABILIZE and RELEASE, so size it for the larger.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW = (CE_DIV > 1)  ? $clog2(CE_DIV)  : 1;

  localparam logic [CW-1:0] LOCK_TERM = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TERM = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_TERM  = DW'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic            lost_q, lost_d;
  logic            run_q, run_d;
  logic            tick_q, tick_d;
  logic            lock_s;

  pll_rst_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      div_q   <= '0;
      lost_q  <= 1'b0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      lost_q  <= lost_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end else if (cnt_q == LOCK_TERM) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // A lock drop while still holding reset is not flagged as lost lock.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TERM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss wins over a simultaneous soft-reset request.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (soft_rst_req) begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same
  // edge as the state register, with no combinational path to the pins.
  // The divider restarts from 0 on every RUN entry and ticks on wrap.
  always_comb begin
    run_d  = (state_d == RUN);
    div_d  = '0;
    tick_d = 1'b0;
    if (run_d && (state_q == RUN)) begin
      if (div_q == DIV_TERM) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  assign sys_rst_n = run_q;
  assign ready     = run_q;
  assign ce_tick   = tick_q;
  assign state     = state_q;
  assign lock_lost = lost_q;
endmodule

// File: tb/tb_pll_rst_sequencer.sv
module tb_pll_rst_sequencer;
  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int CED = 4;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, soft_rst_req;
  logic       sys_rst_n, ready, ce_tick, lock_lost;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, entry edge of the current phase, a
  // two-deep lock history and the sticky flag. Tick timing is derived from
  // the edge distance since RUN entry.
  int cyc = 0;
  int m_st, m_entry;
  bit m_h1, m_h2, m_lost, m_ce;

  pll_rst_sequencer #(
    .LOCK_STABLE_CYCLES (LSC),
    .RST_HOLD_CYCLES    (RHC),
    .CE_DIV             (CED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .ce_tick      (ce_tick),
    .state        (state),
    .lock_lost    (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_entry = cyc; m_h1 = 0; m_h2 = 0; m_lost = 0; m_ce = 0;
  endtask

  task automatic model_edge();
    bit ls;
    int nxt;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = pll_lock;
    nxt  = m_st;
    if (m_st == 0) begin
      if (ls) nxt = 1;
    end else if (!ls) begin
      if (m_st != 2) m_lost = 1;
      nxt = 0;
    end else if (m_st == 1) begin
      if (cyc - m_entry == LSC) nxt = 2;
    end else if (m_st == 2) begin
      if (cyc - m_entry == RHC) nxt = 3;
    end else if (soft_rst_req) begin
      nxt = 2;
    end
    m_ce = (m_st == 3) && (nxt == 3) && ((cyc - m_entry) % CED == 0);
    if (nxt != m_st) m_entry = cyc;
    m_st = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state",     int'(state),     m_st);
    chk("sys_rst_n", int'(sys_rst_n), int'(m_st == 3));
    chk("ready",     int'(ready),     int'(m_st == 3));
    chk("ce_tick",   int'(ce_tick),   int'(m_ce));
    chk("lock_lost", int'(lock_lost), int'(m_lost));
  endtask

  // Drives lock high with the first sample at the next edge k and measures
  // latencies of each phase and of the first three ce strokes relative to k.
  task automatic bringup(input string tg);
    int k, t1, t2, t3, fce, nce;
    pll_lock = 1; soft_rst_req = 0;
    k = cyc + 1; t1 = -1; t2 = -1; t3 = -1; fce = -1; nce = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (t1 < 0 && state == 2'd1) t1 = cyc - k;
      if (t2 < 0 && state == 2'd2) t2 = cyc - k;
      if (t3 < 0 && state == 2'd3 && sys_rst_n && ready) t3 = cyc - k;
      if (ce_tick) begin
        nce++;
        if (fce < 0) fce = cyc - k;
      end
    end
    chk({tg, "_stab_lat"}, t1, 2);
    chk({tg, "_rel_lat"},  t2, 10);
    chk({tg, "_run_lat"},  t3, 14);
    chk({tg, "_ce_first"}, fce, 18);
    chk({tg, "_ce_count"}, nce, 3);
  endtask

  initial begin
    int guard;
    rst_n = 1; pll_lock = 0; soft_rst_req = 0;
    model_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_state",     int'(state),     0);
    chk("rst_sys_rst_n", int'(sys_rst_n), 0);
    chk("rst_ready",     int'(ready),     0);
    chk("rst_ce",        int'(ce_tick),   0);
    chk("rst_lost",      int'(lock_lost), 0);
    repeat (3) tick();
    rst_n = 1;

    // Power-up with lock absent.
    repeat (50) tick();
    chk("pwr_state", int'(state), 0);

    bringup("boot");

    // Glitchy lock during qualification.
    rst_n = 0; #1; model_reset(); rst_n = 1;
    pll_lock = 1;
    guard = 0;
    while (state != 2'd1 && guard < 20) begin tick(); guard++; end
    chk("glitch_reach_stab", int'(state), 1);
    repeat (4) tick();
    pll_lock = 0; tick();
    pll_lock = 1;
    repeat (2) tick();
    chk("glitch_back_wait", int'(state), 0);
    chk("glitch_lost",      int'(lock_lost), 1);
    guard = 0;
    while (state != 2'd3 && guard < 40) begin tick(); guard++; end
    chk("glitch_requal_run", int'(state), 3);

    // Soft reset from RUN.
    repeat (3) tick();
    soft_rst_req = 1; tick(); soft_rst_req = 0;
    chk("soft_state", int'(state),     2);
    chk("soft_srst",  int'(sys_rst_n), 0);
    chk("soft_ready", int'(ready),     0);
    chk("soft_ce",    int'(ce_tick),   0);
    repeat (4) tick();
    chk("soft_rerun", int'(state),     3);
    chk("soft_srst1", int'(sys_rst_n), 1);
    repeat (4) tick();
    chk("soft_ce_first", int'(ce_tick), 1);

    // Async reset between edges while in RUN.
    #2 rst_n = 0;
    #1;
    chk("arst_srst",  int'(sys_rst_n), 0);
    chk("arst_ready", int'(ready),     0);
    chk("arst_ce",    int'(ce_tick),   0);
    chk("arst_state", int'(state),     0);
    chk("arst_lost",  int'(lock_lost), 0);
    model_reset();
    #1 rst_n = 1;
    bringup("rebring");

    // Lock loss and soft request hitting the same RUN edge.
    pll_lock = 0; tick(); tick();
    soft_rst_req = 1; tick(); soft_rst_req = 0;
    chk("simul_state", int'(state),     0);
    chk("simul_lost",  int'(lock_lost), 1);

    // Randomised lock and soft-request traffic.
    rst_n = 0; #1; model_reset(); rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      pll_lock     = ($urandom_range(0, 99) < 97);
      soft_rst_req = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
